// File: rtl/mix_sum_pipe_pkg.sv
// mix_pkg: shared state, mode encodings and arithmetic helpers for the stereo mixer
package mix_pkg;
  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
  localparam logic [1:0] MODE_MIX = 2'b00;
  localparam logic [1:0] MODE_BYP = 2'b01;
  localparam logic [1:0] MODE_MUTE = 2'b10;
  function automatic int acc_w(input int w, input int g, input int n);
    return w + g + $clog2(n);
  endfunction
  function automatic logic signed [63:0] clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/mix_sum_pipe_if.sv
// mix_sum_pipe_if: receiver-side inputs and mixed stereo outputs of the mixer
interface mix_sum_pipe_if #(parameter int NCH = 4, parameter int WIDTH = 24, parameter int GAIN_W = 16);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_lrn;
  logic [NCH-1:0] in_en;
  logic [NCH*GAIN_W-1:0] gain;
  logic [1:0] mode;
  logic [WIDTH-1:0] out_l;
  logic [WIDTH-1:0] out_r;
  logic out_valid;
  logic sat;
  logic overrun;
  modport master(output in_data, in_lrn, in_en, gain, mode, input out_l, out_r, out_valid, sat, overrun);
  modport slave(input in_data, in_lrn, in_en, gain, mode, output out_l, out_r, out_valid, sat, overrun);
endinterface

// File: rtl/mix_sum_pipe_mac.sv
// mix_mac: signed multiply with registered product accumulating into a left or right sum
module mix_mac #(parameter int WIDTH = 24, parameter int GAIN_W = 16, parameter int AW = 42) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sel,
  input  logic signed [WIDTH-1:0]  a,
  input  logic signed [GAIN_W-1:0] b,
  output logic signed [AW-1:0]     acc_l,
  output logic signed [AW-1:0]     acc_r
);
  logic signed [WIDTH+GAIN_W-1:0] prod;
  logic vld, sel_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod <= '0;
      vld <= 1'b0;
      sel_q <= 1'b0;
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      prod <= a * b;
      vld <= en;
      sel_q <= sel;
      if (clr) begin
        acc_l <= '0;
        acc_r <= '0;
      end else if (vld && sel_q) acc_r <= acc_r + AW'(prod);
      else if (vld) acc_l <= acc_l + AW'(prod);
    end
  end
endmodule

// File: rtl/mix_sum_pipe.sv
// mix_sum_pipe: snapshots NCH stereo inputs per frame, gain-mixes them through one MAC, saturates
module mix_sum_pipe import mix_pkg::*; #(parameter int NCH = 4, parameter int WIDTH = 24, parameter int GAIN_W = 16) (
  input logic clk,
  input logic rstn,
  mix_sum_pipe_if.slave bus
);
  localparam int AW = acc_w(WIDTH, GAIN_W, NCH);
  localparam int CW = $clog2(2 * NCH) + 1;
  logic signed [WIDTH-1:0] hold_l[NCH], hold_r[NCH], snap_l[NCH], snap_r[NCH], wt_l[NCH], wt_r[NCH];
  logic signed [GAIN_W-1:0] gain_q[NCH];
  logic [1:0] mode_q;
  state_t state, state_n;
  logic [CW-1:0] cnt, nxt;
  logic trig, take, issue, side;
  logic signed [WIDTH-1:0] op_a;
  logic signed [GAIN_W-1:0] op_b;
  logic signed [AW-1:0] acc_l, acc_r, sh_l, sh_r;
  logic signed [63:0] res_l, res_r, cl_l, cl_r;
  assign trig = bus.in_en[0] && !bus.in_lrn[0];
  assign take = trig && state == IDLE;
  assign nxt = cnt + CW'(1);
  assign issue = take || (state == MAC && cnt < CW'(2 * NCH - 1));
  assign sh_l = acc_l >>> (GAIN_W - 2);
  assign sh_r = acc_r >>> (GAIN_W - 2);
  assign res_l = 64'(sh_l);
  assign res_r = 64'(sh_r);
  assign cl_l = clamp(res_l, WIDTH);
  assign cl_r = clamp(res_r, WIDTH);
  // same-cycle receiver writes pass straight into the snapshot
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wt_l[k] = bus.in_en[k] && bus.in_lrn[k] ? bus.in_data[k*WIDTH +: WIDTH] : hold_l[k];
      wt_r[k] = bus.in_en[k] && !bus.in_lrn[k] ? bus.in_data[k*WIDTH +: WIDTH] : hold_r[k];
    end
  end
  // the first product issues from live inputs at the trigger; MAC cycles issue one step ahead
  always_comb begin
    op_a = wt_l[0];
    op_b = bus.gain[GAIN_W-1:0];
    side = 1'b0;
    if (state == MAC) begin
      side = nxt[0];
      for (int k = 0; k < NCH; k++)
        if (k == int'(nxt >> 1)) begin
          op_a = nxt[0] ? snap_r[k] : snap_l[k];
          op_b = gain_q[k];
        end
    end
  end
  always_comb begin
    state_n = state;
    state_n = take ? MAC : state == MAC && cnt == CW'(2 * NCH - 1) ? SAT : state == SAT ? IDLE : state;
  end
  mix_mac #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .AW(AW)) u_mac (
    .clk(clk), .rstn(rstn), .clr(take), .en(issue), .sel(side),
    .a(op_a), .b(op_b), .acc_l(acc_l), .acc_r(acc_r)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= MODE_MIX;
      for (int k = 0; k < NCH; k++) begin
        hold_l[k] <= '0;
        hold_r[k] <= '0;
        snap_l[k] <= '0;
        snap_r[k] <= '0;
        gain_q[k] <= '0;
      end
    end else begin
      state <= state_n;
      cnt <= state == MAC ? nxt : '0;
      if (take) mode_q <= bus.mode;
      for (int k = 0; k < NCH; k++) begin
        hold_l[k] <= wt_l[k];
        hold_r[k] <= wt_r[k];
        if (take) begin
          snap_l[k] <= wt_l[k];
          snap_r[k] <= wt_r[k];
          gain_q[k] <= bus.gain[k*GAIN_W +: GAIN_W];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.out_l <= '0;
      bus.out_r <= '0;
      bus.out_valid <= 1'b0;
      bus.sat <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.out_valid <= state == SAT;
      bus.overrun <= trig && state != IDLE;
      bus.sat <= state == SAT && mode_q == MODE_MIX && (cl_l != res_l || cl_r != res_r);
      if (state == SAT) begin
        bus.out_l <= mode_q == MODE_MIX ? cl_l[WIDTH-1:0] : mode_q == MODE_BYP ? snap_l[0] : '0;
        bus.out_r <= mode_q == MODE_MIX ? cl_r[WIDTH-1:0] : mode_q == MODE_BYP ? snap_r[0] : '0;
      end
    end
  end
endmodule

// File: tb/tb_mix_sum_pipe.sv
// tb_mix_sum_pipe: directed and random frames checked against a sum-of-products reference
module tb_mix_sum_pipe;
  localparam int NCH = 4, WIDTH = 24, GAIN_W = 16, LAT = 2 * NCH + 2;
  logic clk = 1'b0, rstn = 1'b0;
  int checks = 0, failures = 0;
  logic signed [WIDTH-1:0] mh_l[NCH], mh_r[NCH];
  logic signed [GAIN_W-1:0] mg[NCH];
  logic [WIDTH-1:0] el, er;
  logic es;
  mix_sum_pipe_if #(.NCH(NCH), .WIDTH(WIDTH), .GAIN_W(GAIN_W)) bus();
  mix_sum_pipe #(.NCH(NCH), .WIDTH(WIDTH), .GAIN_W(GAIN_W)) dut(.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(int k, logic left, logic [WIDTH-1:0] d);
    bus.in_en[k] = 1'b1;
    bus.in_lrn[k] = left;
    bus.in_data[k*WIDTH +: WIDTH] = d;
    if (left) mh_l[k] = d;
    else mh_r[k] = d;
  endtask

  task automatic write(int k, logic left, logic [WIDTH-1:0] d);
    put(k, left, d);
    @(negedge clk);
    bus.in_en = '0;
  endtask

  task automatic fire(logic [WIDTH-1:0] r0, int xk = -1, logic [WIDTH-1:0] xd = '0);
    if (xk > 0) put(xk, 1'b1, xd);
    put(0, 1'b0, r0);
    @(negedge clk);
    bus.in_en = '0;
  endtask

  task automatic set_gains();
    for (int k = 0; k < NCH; k++) bus.gain[k*GAIN_W +: GAIN_W] = mg[k];
  endtask

  task automatic clear_holds();
    for (int k = 0; k < NCH; k++) write(k, 1'b1, '0);
    for (int k = 1; k < NCH; k++) write(k, 1'b0, '0);
  endtask

  // floor(sum(x*g) / 2^(GAIN_W-2)) clipped to the sample range
  task automatic model(input logic [1:0] md);
    longint sl, sr, hi, lo;
    logic cl, cr;
    sl = 0; sr = 0; cl = 1'b0; cr = 1'b0;
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -hi - 1;
    for (int k = 0; k < NCH; k++) begin
      sl += longint'(mh_l[k]) * longint'(mg[k]);
      sr += longint'(mh_r[k]) * longint'(mg[k]);
    end
    sl = sl >>> (GAIN_W - 2);
    sr = sr >>> (GAIN_W - 2);
    if (sl > hi) begin sl = hi; cl = 1'b1; end else if (sl < lo) begin sl = lo; cl = 1'b1; end
    if (sr > hi) begin sr = hi; cr = 1'b1; end else if (sr < lo) begin sr = lo; cr = 1'b1; end
    el = md == 2'b00 ? sl[WIDTH-1:0] : md == 2'b01 ? mh_l[0] : '0;
    er = md == 2'b00 ? sr[WIDTH-1:0] : md == 2'b01 ? mh_r[0] : '0;
    es = md == 2'b00 && (cl || cr);
  endtask

  task automatic await(string tag, int n0);
    int n = n0;
    while (!bus.out_valid && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(LAT));
    chk({tag, " out_l"}, 64'(bus.out_l), 64'(el));
    chk({tag, " out_r"}, 64'(bus.out_r), 64'(er));
    chk({tag, " sat"}, 64'(bus.sat), 64'(es));
    @(negedge clk);
    chk({tag, " pulse"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic quiet(string tag, int cycles);
    int extra = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk(tag, 64'(extra), 64'd0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, " out_l"}, 64'(bus.out_l), 64'd0);
    chk({tag, " out_r"}, 64'(bus.out_r), 64'd0);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " sat"}, 64'(bus.sat), 64'd0);
    chk({tag, " overrun"}, 64'(bus.overrun), 64'd0);
  endtask

  initial begin
    bus.in_en = '0; bus.in_lrn = '0; bus.in_data = '0; bus.gain = '0; bus.mode = 2'b00;
    for (int k = 0; k < NCH; k++) begin mh_l[k] = '0; mh_r[k] = '0; mg[k] = '0; end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NCH; k++) mg[k] = 16'sh4000;
    set_gains();
    write(0, 1'b1, 24'h100000);
    fire(24'h000200);
    model(2'b00);
    await("unity", 1);
    for (int k = 0; k < NCH; k++) write(k, 1'b1, 24'h7FFFFF);
    for (int k = 1; k < NCH; k++) write(k, 1'b0, 24'h800000);
    fire(24'h800000);
    model(2'b00);
    await("saturate", 1);
    clear_holds();
    mg[0] = '0; mg[1] = 16'sh2000; mg[2] = 16'sh2000; mg[3] = '0;
    set_gains();
    write(1, 1'b1, 24'h800000);
    write(2, 1'b0, 24'h000003);
    fire(24'h000000);
    model(2'b00);
    await("scale", 1);
    for (int k = 0; k < NCH; k++) mg[k] = '0;
    set_gains();
    bus.mode = 2'b01;
    write(0, 1'b1, 24'h123456);
    fire(24'h654321);
    model(2'b01);
    await("bypass", 1);
    fire(24'h654321);
    model(2'b01);
    repeat (2) @(negedge clk);
    bus.mode = 2'b10;
    await("mode hold", 3);
    fire(24'h654321);
    model(2'b10);
    await("mute", 1);
    bus.mode = 2'b00;
    for (int k = 0; k < NCH; k++) mg[k] = 16'sh4000;
    set_gains();
    clear_holds();
    write(1, 1'b1, 24'h000010);
    fire(24'h000011, 3, 24'h000400);
    model(2'b00);
    repeat (2) @(negedge clk);
    fire(24'h000022);
    chk("overrun pulse", 64'(bus.overrun), 64'd1);
    await("overrun frame", 4);
    quiet("overrun single valid", 2 * LAT);
    fire(24'h000033);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_zero("mid reset");
    for (int k = 0; k < NCH; k++) begin mh_l[k] = '0; mh_r[k] = '0; end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    quiet("reset abort", LAT + 4);
    write(2, 1'b1, 24'h000123);
    fire(24'hFFFF00);
    model(2'b00);
    await("after reset", 1);
    for (int it = 0; it < 8; it++) begin
      logic [1:0] md;
      md = it % 4 == 3 ? 2'b01 : 2'b00;
      bus.mode = md;
      for (int k = 0; k < NCH; k++) mg[k] = GAIN_W'($urandom);
      set_gains();
      for (int k = 0; k < NCH; k++) write(k, 1'b1, WIDTH'($urandom));
      for (int k = 1; k < NCH; k++) write(k, 1'b0, WIDTH'($urandom >> (it % 8)));
      fire(WIDTH'($urandom));
      model(md);
      await("random", 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mix_sum_pipe.md
# mix_sum_pipe

Parametrised successor to the single-stereo-pair loopback: collects stereo words from `NCH` I2S receivers and applies a signed per-input gain. It sums each side with one time-multiplexed multiplier, saturates, and presents one stereo word per frame to the I2S transmitter. It runs entirely in the mclk domain, between the `i2sin` instances and `i2sout`.

## Interface
- `NCH`, 4, number of stereo input channels (1–16)
- `WIDTH`, 24, sample width, signed two's complement
- `GAIN_W`, 16, gain width, signed Q2.(GAIN_W-2); 0x4000 = 1.0 at default
- `clk` in 1: mclk, the single clock; all logic is on its rising edge
- `rstn` in 1: asynchronous, active-low reset
- `in_data` in NCH*WIDTH: per-channel received word; channel k is at bits [k*WIDTH +: WIDTH]
- `in_lrn` in NCH: per-channel side of the word; 1 = left, 0 = right
- `in_en` in NCH: per-channel one-cycle word strobe
- `gain` in NCH*GAIN_W: per-channel gain, static between frames
- `mode` in 2: 00 mix, 01 bypass ch0, 10 or 11 mute
- `out_l`, `out_r` out WIDTH each: mixed output words, registered
- `out_valid` out 1: one-cycle pulse when `out_l`/`out_r` update
- `sat` out 1: one-cycle pulse, coincident with `out_valid`, when either side clipped
- `overrun` out 1: one-cycle pulse when a frame trigger is dropped

## Operation
- **Holding bank:** `hold_l[k]` and `hold_r[k]` load `in_data[k]` when `in_en[k]` is high, selected by `in_lrn[k]`.
- **Frame trigger:** `in_en[0] && !in_lrn[0]`, the ch0 right word completing a frame.
- **Snapshot on trigger in IDLE:**
  - Copy the whole holding bank into the snapshot bank.
  - A same-cycle `in_en[k]` write is included in the snapshot (write-through mux).
  - Latch `mode` and `gain`. Changes to either take effect only at the next snapshot.
- **FSM states:** IDLE → MAC → SAT → IDLE.
  - MAC lasts 2*NCH cycles. The step index i runs 0..2NCH-1; channel = i>>1; even i = left, odd i = right.
  - Each step adds `snap * gain_k` (WIDTH+GAIN_W bits, signed) into `acc_l` or `acc_r`.
  - Each accumulator is WIDTH+GAIN_W+clog2(NCH) bits and is cleared at snapshot.
- **SAT state:**
  - Compute `res = acc >>> (GAIN_W-2)` (truncation toward −inf).
  - Clamp `res` to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - Set the `sat` condition if either side clamped.
- **Output register:** loads in the cycle after SAT, and `out_valid` pulses.
- **Bypass mode:** outputs ch0 snapshot L/R unscaled; `sat` = 0.
- **Mute mode:** outputs 0/0; `sat` = 0.
  - In both modes the FSM still walks MAC/SAT, so latency is identical in all modes.
- **Trigger while not IDLE:** the trigger is ignored and `overrun` pulses next cycle. The holding bank still updates.
- **Reset:**
  - Asynchronous clear of all registers: holding, snapshot, accumulators, FSM → IDLE.
  - Outputs reset to `out_l`=0, `out_r`=0, `out_valid`=0, `sat`=0, `overrun`=0.
  - Reset mid-MAC aborts the frame with no `out_valid`.

## Timing
- Trigger sampled at edge 0; MAC runs in cycles 1..2NCH; SAT in cycle 2NCH+1.
- `out_valid` is high in cycle 2NCH+2, which is 10 cycles at NCH=4. `out_l`/`out_r` hold until the next pulse.
- Throughput is one frame per 2NCH+2 cycles, far below one I2S frame (≥512 mclk at log2clkdiv=3), so `overrun` indicates a receiver fault.
- Multiplier product is registered once inside the MAC; accumulate depth is absorbed in the 2NCH count, with the last add landing before SAT.
- `in_en` on non-zero channels may arrive at any cycle relative to the trigger.

## Structure
- `mix_pkg`:
  - FSM state encodings: IDLE, MAC, SAT.
  - `mode` constants: MODE_MIX, MODE_BYP, MODE_MUTE.
  - `ACC_W` function of WIDTH, GAIN_W, NCH.
  - Saturating-clamp function.
- One sub-module, `mix_mac`:
  - Signed WIDTH×GAIN_W multiply with registered product.
  - Accumulate into one of two accumulators via a select input, with a synchronous clear.
- Top level holds the banks, trigger detect, FSM, step counter and output registers.

## Test plan
- **Unity pass:** NCH=4, all gains 0x4000, ch0 L=0x100000, R=0x000200, others 0 → `out_l`=0x100000, `out_r`=0x000200, `out_valid` 10 cycles after trigger, `sat`=0.
- **Saturation:** all four L=0x7FFFFF, R=0x800000, gain 0x4000 → `out_l`=0x7FFFFF, `out_r`=0x800000, `sat` pulse with `out_valid`.
- **Scaling/sign:** ch1 L=0x800000, gain 0x2000, others gain 0 → `out_l`=0xC00000; ch2 R=0x000003, gain 0x2000 → `out_r`=0x000001 (truncation).
- **Modes:**
  - `mode`=01 with ch0=0x123456/0x654321 and gains 0 → outputs are ch0 words.
  - Switching to 10 mid-MAC does not affect the current frame; the next frame outputs 0/0.
- **Overrun and simultaneous write:**
  - A second trigger 3 cycles after the first → `overrun` pulse, exactly one `out_valid`.
  - `in_en[3]` in the trigger cycle is reflected in that frame's sum.
- **Reset mid-MAC:** deassert `rstn` at cycle 4 → all outputs 0 immediately and no `out_valid`. After release, the next trigger produces a correct frame.
